axis_pulse_generator: RTL
=========================

// Module: axis_pulse_generator
// PURPOSE
//   AXIS master that synthesises a programmable train of rectangular photon-like pulses as
//   14-bit signed DAC samples. Loop-back stimulus source for the threshold pulse counter:
//   each pulse swings from LOW_LEVEL to HIGH_LEVEL and back, so the counter sees one rising edge.
//   Sits between PS-side configuration registers and the DAC AXIS input (125 MHz domain).
// PARAMETERS
//   ADC_WIDTH         14        sample width in bits (signed, two's complement)
//   AXIS_TDATA_WIDTH  32        AXIS tdata width; sample is sign-extended into it
//   COUNT_WIDTH       32        width of n_pulses and pulses_sent
//   LEN_WIDTH         16        width of high_len and low_len (unit: accepted beats)
//   HIGH_LEVEL        14'sd8000 pulse-top sample value
//   LOW_LEVEL         14'sd0    baseline sample value
// PORTS
//   clk                 in   1                 sample clock, 125 MHz
//   rst                 in   1                 asynchronous, active-low reset
//   start               in   1                 1-cycle request; launches a train when idle
//   abort               in   1                 level; ends the train at the next accepted beat
//   n_pulses            in   COUNT_WIDTH       pulses per train, sampled on start
//   high_len            in   LEN_WIDTH         beats at HIGH_LEVEL per pulse, sampled on start
//   low_len             in   LEN_WIDTH         beats at LOW_LEVEL after each pulse, sampled on start
//   M_AXIS_OUT_tdata    out  AXIS_TDATA_WIDTH  sign-extended sample
//   M_AXIS_OUT_tvalid   out  1                 sample valid
//   M_AXIS_OUT_tready   in   1                 downstream accept
//   busy                out  1                 train in progress
//   done                out  1                 1-cycle strobe when a train completes or aborts
//   pulses_sent         out  COUNT_WIDTH       pulses completed in the current/last train
// BEHAVIOUR
//   - Reset (rst=0): state IDLE, tvalid=0, tdata=0, busy=0, done=0, pulses_sent=0, config regs 0.
//     From the first clk edge after release: tvalid=1 permanently, tdata=LOW_LEVEL while IDLE.
//   - All outputs registered. Beat = cycle with tvalid & tready. While tready=0, tdata is held
//     stable and no counter advances (AXIS rule; no beat is dropped or duplicated).
//   - FSM: IDLE -> HIGH -> LOW -> (HIGH | IDLE).
//     IDLE: start=1 and n_pulses!=0 -> latch config, clear pulses_sent, busy=1, goto HIGH.
//       A beat pending in IDLE (tready=0) is completed first; HIGH tdata is presented on the
//       cycle after the launch edge. start with n_pulses=0 -> no state change, done=1 next cycle.
//     HIGH: emit HIGH_LEVEL for max(high_len,1) beats; on the last accepted HIGH beat
//       pulses_sent+=1 (wraps mod 2^COUNT_WIDTH), goto LOW.
//     LOW: emit LOW_LEVEL for max(low_len,1) beats; on the last beat, if pulses_sent==n_pulses
//       goto IDLE with busy=0 and done=1 for one cycle, else goto HIGH.
//   - Zero lengths are forced to 1 so every pulse produces one rising and one falling edge.
//   - start while busy: ignored. Config port changes while busy: ignored (latched copy used).
//   - abort=1 in HIGH/LOW: on the next accepted beat go to IDLE (LOW_LEVEL), busy=0, done=1;
//     pulses_sent keeps its value, incl. the increment if that beat ended a HIGH segment.
//     abort and start in the same IDLE cycle: start wins, abort ignored in IDLE.
//   - Reset asserted mid-train: immediate return to reset values; no done strobe.
//   - tdata[AXIS_TDATA_WIDTH-1:ADC_WIDTH] = sign-extension of tdata[ADC_WIDTH-1] (tdata=0 in reset).
// STRUCTURE
//   - Shared header pulse_gen_defs.vh: FSM state localparams (IDLE=2'd0, HIGH=2'd1, LOW=2'd2),
//     default HIGH_LEVEL/LOW_LEVEL constants shared with the counter testbench.
//   - One sub-module: beat_down_counter (load value, decrement on beat, last flag), instanced
//     once and reloaded per segment. FSM, pulse counter and AXIS register in the top.
// TESTING
//   1 n_pulses=3, high_len=4, low_len=6, tready=1 -> 30 beats: (4x8000,6x0)x3, done at beat 30, pulses_sent=3.
//   2 Same config, tready toggled pseudo-randomly -> accepted-beat sequence identical to test 1; tdata stable when stalled.
//   3 high_len=0, low_len=0, n_pulses=2 -> beats 8000,0,8000,0 then idle LOW_LEVEL, done once.
//   4 abort on the 2nd beat of pulse 2 (n=5,h=4,l=4) -> IDLE after that beat, pulses_sent=1, done=1.
//   5 start with n_pulses=0 -> tdata stays 0, busy stays 0, done=1 one cycle later; start while busy ignored.
//   6 rst low mid-HIGH -> tvalid=0/tdata=0 same cycle (async); after release tvalid=1, LOW_LEVEL, no done.
//   Loop-back: drive frequency counter input with tests 1/3 -> its count advances by exactly n_pulses.

Source files
------------

// File: rtl/axis_pulse_generator_pkg.sv
// Shared definitions for the AXIS pulse-train generator: FSM encoding and
// default pulse levels (also used by the loop-back counter bench).
package axis_pulse_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pg_state_t;

  localparam logic signed [13:0] PG_HIGH_LEVEL = 14'sd8000;
  localparam logic signed [13:0] PG_LOW_LEVEL  = 14'sd0;

endpackage

// File: rtl/axis_pulse_generator_counter.sv
// Segment length counter: loaded with a beat count, decremented per accepted
// beat; o_last flags the final beat of the segment.
module beat_down_counter
  import axis_pulse_generator_pkg::*;
#(
  parameter int W = 16
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - W'(1);
  end

  assign o_last = (r_cnt <= W'(1));

endmodule

// File: rtl/axis_pulse_generator.sv
// AXIS master emitting a programmable train of rectangular pulses as
// sign-extended DAC samples; FSM, pulse counter and output register live here.
module axis_pulse_generator
  import axis_pulse_generator_pkg::*;
#(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int COUNT_WIDTH      = 32,
  parameter int LEN_WIDTH        = 16,
  parameter logic signed [ADC_WIDTH-1:0] HIGH_LEVEL = PG_HIGH_LEVEL,
  parameter logic signed [ADC_WIDTH-1:0] LOW_LEVEL  = PG_LOW_LEVEL
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [COUNT_WIDTH-1:0]      n_pulses,
  input  logic [LEN_WIDTH-1:0]        high_len,
  input  logic [LEN_WIDTH-1:0]        low_len,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  input  logic                        M_AXIS_OUT_tready,
  output logic                        busy,
  output logic                        done,
  output logic [COUNT_WIDTH-1:0]      pulses_sent
);

  pg_state_t                   r_state, w_state_nxt;
  logic                        r_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] r_tdata, w_tdata_nxt;
  logic                        r_busy, w_busy_nxt;
  logic                        r_done, w_done_nxt;
  logic                        r_pend, w_pend_nxt;
  logic [COUNT_WIDTH-1:0]      r_pulses_sent, w_ps_nxt;
  logic [COUNT_WIDTH-1:0]      r_n_pulses;
  logic [LEN_WIDTH-1:0]        r_high_len, r_low_len;
  logic                        w_cfg_ld;
  logic                        w_cnt_ld, w_cnt_dec, w_cnt_last;
  logic [LEN_WIDTH-1:0]        w_cnt_val;
  logic [LEN_WIDTH-1:0]        w_hl_in, w_hl_cfg, w_ll_cfg;
  logic                        w_beat, w_adv;
  logic signed [ADC_WIDTH-1:0] w_sample;

  assign w_beat = r_tvalid & M_AXIS_OUT_tready;
  // Output register may load a new sample only when nothing is pending on the bus.
  assign w_adv  = ~r_tvalid | M_AXIS_OUT_tready;

  // Zero lengths become one beat so every pulse still has both edges.
  assign w_hl_in  = (high_len   == '0) ? LEN_WIDTH'(1) : high_len;
  assign w_hl_cfg = (r_high_len == '0) ? LEN_WIDTH'(1) : r_high_len;
  assign w_ll_cfg = (r_low_len  == '0) ? LEN_WIDTH'(1) : r_low_len;

  beat_down_counter #(.W(LEN_WIDTH)) u_cnt (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_load     (w_cnt_ld),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_last     (w_cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pend_nxt  = r_pend;
    w_ps_nxt    = r_pulses_sent;
    w_cfg_ld    = 1'b0;
    w_cnt_ld    = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cnt_val   = w_hl_cfg;
    case (r_state)
      ST_IDLE: begin
        // A launch seen while an idle beat is stalled waits for that beat.
        if (r_pend) begin
          if (w_adv) begin
            w_state_nxt = ST_HIGH;
            w_pend_nxt  = 1'b0;
            w_cnt_ld    = 1'b1;
          end
        end else if (start) begin
          if (n_pulses == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_cfg_ld   = 1'b1;
            w_ps_nxt   = '0;
            w_busy_nxt = 1'b1;
            if (w_adv) begin
              w_state_nxt = ST_HIGH;
              w_cnt_ld    = 1'b1;
              w_cnt_val   = w_hl_in;
            end else begin
              w_pend_nxt = 1'b1;
            end
          end
        end
      end
      ST_HIGH: begin
        if (w_beat) begin
          if (w_cnt_last) w_ps_nxt = r_pulses_sent + COUNT_WIDTH'(1);
          if (abort) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else if (w_cnt_last) begin
            w_state_nxt = ST_LOW;
            w_cnt_ld    = 1'b1;
            w_cnt_val   = w_ll_cfg;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (w_beat) begin
          if (abort || (w_cnt_last && (r_pulses_sent == r_n_pulses))) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else if (w_cnt_last) begin
            w_state_nxt = ST_HIGH;
            w_cnt_ld    = 1'b1;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_sample    = (w_state_nxt == ST_HIGH) ? HIGH_LEVEL : LOW_LEVEL;
  assign w_tdata_nxt = {{(AXIS_TDATA_WIDTH-ADC_WIDTH){w_sample[ADC_WIDTH-1]}}, w_sample};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tvalid      <= 1'b0;
      r_tdata       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pend        <= 1'b0;
      r_pulses_sent <= '0;
      r_n_pulses    <= '0;
      r_high_len    <= '0;
      r_low_len     <= '0;
    end else begin
      r_tvalid      <= 1'b1;
      if (w_adv) r_tdata <= w_tdata_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_pend        <= w_pend_nxt;
      r_pulses_sent <= w_ps_nxt;
      if (w_cfg_ld) begin
        r_n_pulses <= n_pulses;
        r_high_len <= high_len;
        r_low_len  <= low_len;
      end
    end
  end

  assign M_AXIS_OUT_tdata  = r_tdata;
  assign M_AXIS_OUT_tvalid = r_tvalid;
  assign busy              = r_busy;
  assign done              = r_done;
  assign pulses_sent       = r_pulses_sent;

endmodule
